plaintext_reorder_buffer: RTL and testbench



---
 rtl/aes_pkg.sv | 7 +
 rtl/pt_buf_ram.sv | 26 ++
 rtl/plaintext_reorder_buffer.sv | 143 ++++++++++++++
 tb/tb_plaintext_reorder_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath defaults used by the plaintext reorder buffer.
package aes_pkg;

  localparam int unsigned PT_DATA_W = 128;
  localparam int unsigned PT_DEPTH  = 16;

endpackage

// File: rtl/pt_buf_ram.sv
// Plaintext slot storage: one synchronous write port, one asynchronous read port, no reset.
module pt_buf_ram #(
  parameter  int unsigned DATA_W = 128,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store accepted plaintext blocks.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/plaintext_reorder_buffer.sv
// Reorder buffer for decrypted blocks: slots are filled by index in any order and drained in
// slot order through a valid/ready output register.
// Optional build macro PT_BUF_ECHO_EN adds echo_q_o, a registered copy of every wr_data_i.
module plaintext_reorder_buffer
  import aes_pkg::*;
#(
  parameter  int unsigned DATA_W = PT_DATA_W,
  parameter  int unsigned DEPTH  = PT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [ADDR_W:0]   pending_o,
  output logic              err_o
`ifdef PT_BUF_ECHO_EN
  ,
  output logic [DATA_W-1:0] echo_q_o
`endif
);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic              r_err;
  logic [ADDR_W:0]   r_pending;

  logic              w_free;
  logic              w_adv;
  logic              w_wr_ok;
  logic              w_wr_err;
  logic [DATA_W-1:0] w_rd_data;
  logic [DEPTH-1:0]  w_valid_d;
  logic [ADDR_W:0]   w_pending_d;

  // Validity is taken from the registered bits, so a write racing a drain of the same slot
  // sees it still occupied and is rejected.
  assign w_free   = !r_out_valid || out_ready_i;
  assign w_adv    = w_free && r_valid[r_rd_ptr];
  assign w_wr_ok  = wr_en_i && !r_valid[wr_addr_i];
  assign w_wr_err = wr_en_i && r_valid[wr_addr_i];

  pt_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_wr_ok && !flush_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_rd_data)
  );

  // Next valid bits and fill count; an accepted write never targets the head being drained.
  always_comb begin
    w_valid_d   = r_valid;
    w_pending_d = r_pending;
    if (w_adv) begin
      w_valid_d[r_rd_ptr] = 1'b0;
    end
    if (w_wr_ok) begin
      w_valid_d[wr_addr_i] = 1'b1;
    end
    if (w_wr_ok && !w_adv) begin
      w_pending_d = r_pending + (ADDR_W + 1)'(1);
    end else if (!w_wr_ok && w_adv) begin
      w_pending_d = r_pending - (ADDR_W + 1)'(1);
    end
  end

  // Slot bookkeeping, read pointer and sticky error; flush overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid   <= '0;
      r_rd_ptr  <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else if (flush_i) begin
      r_valid   <= '0;
      r_rd_ptr  <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_valid   <= w_valid_d;
      r_pending <= w_pending_d;
      if (w_adv) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output stage: load the head slot when free, hold while stalled, drop valid when drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_rd_data;
      r_out_addr  <= r_rd_ptr;
    end else if (w_free) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef PT_BUF_ECHO_EN
  logic [DATA_W-1:0] r_echo;

  // Legacy echo of every write request, accepted or not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_echo <= '0;
    end else if (wr_en_i && !flush_i) begin
      r_echo <= wr_data_i;
    end
  end

  assign echo_q_o = r_echo;
`endif

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_addr_o  = r_out_addr;
  assign pending_o   = r_pending;
  assign err_o       = r_err;

endmodule

// File: tb/tb_plaintext_reorder_buffer.sv
// Scoreboard bench: a slot-level reference model predicts every block released and the
// status outputs; a negedge monitor compares them against the DUT.
module tb_plaintext_reorder_buffer;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [AW-1:0] out_addr_o;
  logic [AW:0]   pending_o;
  logic          err_o;

  always #5 clk = ~clk;

  plaintext_reorder_buffer #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_addr_o  (out_addr_o),
    .pending_o   (pending_o),
    .err_o       (err_o)
  );

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  bit            m_valid[DP];
  logic [DW-1:0] m_mem[DP];
  int            m_rd;
  bit            m_ov;
  bit            m_err;
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, then advances the reference model by the same cycle.
  task automatic step(input bit fl, input bit wr, input int a, input logic [DW-1:0] d,
                      input bit rdy);
    bit pv[DP];
    bit free;
    flush_i     = fl;
    wr_en_i     = wr;
    wr_addr_i   = AW'(a);
    wr_data_i   = d;
    out_ready_i = rdy;
    @(posedge clk);
    #1;
    if (fl) begin
      for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
      m_rd  = 0;
      m_ov  = 1'b0;
      m_err = 1'b0;
      q.delete();
    end else begin
      pv   = m_valid;
      free = !m_ov || rdy;
      if (wr) begin
        if (pv[a]) m_err = 1'b1;
        else begin
          m_valid[a] = 1'b1;
          m_mem[a]   = d;
        end
      end
      if (free) begin
        if (pv[m_rd]) begin
          q.push_back('{m_rd, m_mem[m_rd]});
          m_valid[m_rd] = 1'b0;
          m_rd          = (m_rd + 1) % DP;
          m_ov          = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, rdy);
  endtask

  // Monitor: status every cycle, head block against the scoreboard, pop on handshake.
  always @(negedge clk) begin
    int cnt;
    if (mon_en) begin
      cnt = 0;
      for (int i = 0; i < DP; i++) cnt += int'(m_valid[i]);
      check("pending", 64'(pending_o), 64'(cnt));
      check("err", 64'(err_o), 64'(m_err));
      check("out_valid", 64'(out_valid_o), 64'(m_ov));
      if (out_valid_o && m_ov) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=valid required=no_block at %0t", $time);
        end else begin
          check("out_data", 64'(out_data_o), 64'(q[0].data));
          check("out_addr", 64'(out_addr_o), 64'(q[0].addr));
          if (out_ready_i) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    wr_en_i     = 1'b0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    out_ready_i = 1'b0;
    m_rd        = 0;
    m_ov        = 1'b0;
    m_err       = 1'b0;
    for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("reset_out_data", 64'(out_data_o), 64'h0);
    check("reset_out_addr", 64'(out_addr_o), 64'h0);
    check("reset_pending", 64'(pending_o), 64'h0);
    check("reset_out_valid", 64'(out_valid_o), 64'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // In-order fill.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, i, 32'hA0 + i, 1'b1);
    idle(4, 1'b1);
    // Out-of-order fill.
    step(1'b1, 1'b0, 0, '0, 1'b1);
    for (int i = 2; i >= 0; i--) step(1'b0, 1'b1, i, 32'hB0 + i, 1'b1);
    idle(4, 1'b1);
    // Back-pressure, then release.
    step(1'b1, 1'b0, 0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, i, 32'hC0 + i, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);
    // Overwrite of an undrained slot.
    step(1'b0, 1'b1, 1, 32'hD1, 1'b0);
    step(1'b0, 1'b1, 1, 32'hDEAD, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);
    // Full and wrap.
    step(1'b1, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < DP; i++) step(1'b0, 1'b1, i, 32'hE0 + i, 1'b0);
    step(1'b0, 1'b1, 2, 32'hBAD, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 0, 32'hF0, 1'b0);
    step(1'b0, 1'b1, 1, 32'hF1, 1'b0);
    idle(2, 1'b0);
    idle(8, 1'b1);
    // Flush with pending slots and a same-cycle write.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, i, 32'h10 + i, 1'b0);
    step(1'b1, 1'b1, 3, 32'h13, 1'b0);
    step(1'b0, 1'b1, 0, 32'h20, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 64) == 0, ($urandom % 3) != 0, int'($urandom % DP), $urandom,
           ($urandom % 4) != 0);
    end
    idle(2 * DP + 2, 1'b1);
    check("final_queue_empty", 64'(q.size()), 64'h0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
